// File: rtl/gsense_pkg.sv
// Shared definitions for the gsense transmit and receive lanes.
//   FIRST_BIT_LSB / FIRST_BIT_MSB : legal values of the FIRST_BIT parameter
//   bit_swap                      : full-width bit reversal (caller shifts/truncates)
//   nslot                         : number of SER_WIDTH chunks per DATA_BITS word
package gsense_pkg;

    localparam string FIRST_BIT_LSB = "LSB";
    localparam string FIRST_BIT_MSB = "MSB";

    // Widest word bit_swap can handle.
    localparam int SWAP_MAX = 32;

    // Reverses all SWAP_MAX bits. For a narrower word placed in the low bits,
    // shift the result right by (SWAP_MAX - width) to bring it back down.
    function automatic logic [SWAP_MAX-1:0] bit_swap(input logic [SWAP_MAX-1:0] value);
        logic [SWAP_MAX-1:0] result;
        result = '0;
        for (int i = 0; i < SWAP_MAX; i++) begin
            result[i] = value[SWAP_MAX-1-i];
        end
        return result;
    endfunction

    function automatic int nslot(input int data_bits, input int ser_width);
        return data_bits / ser_width;
    endfunction

endpackage

// File: rtl/gsense_tx_if.sv
// Word handshake between a word source and the transmit lane.
//   s_valid : source has a word on s_data
//   s_data  : DATA_BITS-wide word
//   s_ready : lane accepts the word this cycle (transfer = s_valid && s_ready)
interface gsense_tx_if #(
    parameter int DATA_BITS = 12
);
    logic                 s_valid;
    logic [DATA_BITS-1:0] s_data;
    logic                 s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/gsense_tx_gearbox.sv
// History register and slip/slot window extraction.
//   clkdiv, rst : clock, async active-high reset
//   wire_word   : next word in wire order (bit 0 first on the wire)
//   load        : shift wire_word into the history on this edge
//   slot        : slot index that will be current after this edge
//   slip        : bit delay that will be current after this edge
//   ser_data    : registered chunk for the OSERDES
module gsense_tx_gearbox
    import gsense_pkg::*;
#(
    parameter int DATA_BITS = 12,
    parameter int SER_WIDTH = 6
) (
    input  logic                 clkdiv,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] wire_word,
    input  logic                 load,
    input  logic                 slot,
    input  logic [3:0]           slip,
    output logic [SER_WIDTH-1:0] ser_data
);

    localparam int HIST_BITS = 2 * DATA_BITS;
    localparam int IDX_BITS  = $clog2(HIST_BITS);

    // {current word, previous word}
    logic [HIST_BITS-1:0] hist_r;
    logic [HIST_BITS-1:0] hist_nxt_s;
    logic [IDX_BITS-1:0]  base_s;
    logic [SER_WIDTH-1:0] ser_data_r;

    // Next history value and the window base for the upcoming slot. The
    // window is computed from next-state values so ser_data can be registered
    // without adding a cycle of latency.
    always_comb begin
        hist_nxt_s = hist_r;
        if (load) begin
            hist_nxt_s = {wire_word, hist_r[HIST_BITS-1:DATA_BITS]};
        end else begin
            hist_nxt_s = hist_r;
        end
        base_s = IDX_BITS'(DATA_BITS) + IDX_BITS'(slot) * IDX_BITS'(SER_WIDTH) - IDX_BITS'(slip);
    end

    // History and output chunk registers.
    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            hist_r     <= '0;
            ser_data_r <= '0;
        end else begin
            hist_r     <= hist_nxt_s;
            ser_data_r <= hist_nxt_s[base_s +: SER_WIDTH];
        end
    end

    assign ser_data = ser_data_r;

endmodule

// File: rtl/gsense_tx_lane.sv
// Single-lane transmit framer feeding an external OSERDES.
//   clkdiv, rst       : sole clock, async active-high reset
//   training_pattern  : word sent while training or when no data is offered
//   train             : 1 = send training pattern only
//   slip_offset       : extra bit delay of the stream (clamped to DATA_BITS-1)
//   s_if              : word handshake (slave side)
//   ser_data          : chunk to OSERDES, bit 0 leaves first
//   training_active   : current word is training/idle fill
//   underflow_cnt     : saturating count of idle words inserted while train=0
module gsense_tx_lane
    import gsense_pkg::*;
#(
    parameter int    DATA_BITS = 12,
    parameter int    SER_WIDTH = 6,
    parameter string FIRST_BIT = "LSB"
) (
    input  logic                 clkdiv,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] training_pattern,
    input  logic                 train,
    input  logic [3:0]           slip_offset,
    gsense_tx_if.slave           s_if,
    output logic [SER_WIDTH-1:0] ser_data,
    output logic                 training_active,
    output logic [15:0]          underflow_cnt
);

    localparam int   NSLOT      = nslot(DATA_BITS, SER_WIDTH);
    localparam logic LAST_SLOT  = (NSLOT == 2) ? 1'b1 : 1'b0;
    localparam bit   MSB_FIRST  = (FIRST_BIT == FIRST_BIT_MSB);
    localparam int   SWAP_SHIFT = SWAP_MAX - DATA_BITS;

    if (!((NSLOT == 1) || (NSLOT == 2)) || (NSLOT * SER_WIDTH != DATA_BITS)) begin : g_bad_geometry
        $error("gsense_tx_lane: DATA_BITS/SER_WIDTH must be exactly 1 or 2");
    end
    if (!((FIRST_BIT == FIRST_BIT_LSB) || (FIRST_BIT == FIRST_BIT_MSB))) begin : g_bad_first_bit
        $error("gsense_tx_lane: FIRST_BIT must be \"LSB\" or \"MSB\"");
    end
    if (DATA_BITS > SWAP_MAX) begin : g_bad_width
        $error("gsense_tx_lane: DATA_BITS exceeds bit_swap width");
    end

    logic                 slot_r;
    logic [3:0]           slip_r;
    logic                 training_active_r;
    logic [15:0]          underflow_cnt_r;

    logic                 boundary_s;
    logic                 slot_nxt_s;
    logic [3:0]           slip_clamp_s;
    logic [3:0]           slip_nxt_s;
    logic [DATA_BITS-1:0] word_sel_s;
    logic [DATA_BITS-1:0] wire_word_s;
    logic                 fill_s;
    logic                 bump_s;

    assign boundary_s   = (slot_r == LAST_SLOT);
    assign slot_nxt_s   = boundary_s ? 1'b0 : (slot_r + 1'b1);
    assign slip_clamp_s = (slip_offset > 4'(DATA_BITS - 1)) ? 4'(DATA_BITS - 1) : slip_offset;
    assign slip_nxt_s   = boundary_s ? slip_clamp_s : slip_r;

    // Decoded from state only; rst holds it low so nothing is offered while
    // the lane is in reset (matters when NSLOT=1 and every cycle is a boundary).
    assign s_if.s_ready = boundary_s && !train && !rst;

    // Word selection: training beats data, data beats idle fill.
    always_comb begin
        word_sel_s = training_pattern;
        fill_s     = 1'b1;
        bump_s     = 1'b0;
        if (train) begin
            word_sel_s = training_pattern;
            fill_s     = 1'b1;
        end else if (s_if.s_valid) begin
            word_sel_s = s_if.s_data;
            fill_s     = 1'b0;
        end else begin
            word_sel_s = training_pattern;
            fill_s     = 1'b1;
            bump_s     = 1'b1;
        end
    end

    // Wire order: W[0] is the first bit on the wire.
    always_comb begin
        wire_word_s = word_sel_s;
        if (MSB_FIRST) begin
            wire_word_s = DATA_BITS'(bit_swap(SWAP_MAX'(word_sel_s)) >> SWAP_SHIFT);
        end else begin
            wire_word_s = word_sel_s;
        end
    end

    // Slot counter, latched slip, word-type flag and underflow counter.
    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            slot_r            <= 1'b0;
            slip_r            <= 4'd0;
            training_active_r <= 1'b1;
            underflow_cnt_r   <= 16'd0;
        end else begin
            slot_r <= slot_nxt_s;
            slip_r <= slip_nxt_s;
            if (boundary_s) begin
                training_active_r <= fill_s;
                if (bump_s && (underflow_cnt_r != 16'hFFFF)) begin
                    underflow_cnt_r <= underflow_cnt_r + 16'd1;
                end
            end
        end
    end

    gsense_tx_gearbox #(
        .DATA_BITS (DATA_BITS),
        .SER_WIDTH (SER_WIDTH)
    ) u_gearbox (
        .clkdiv    (clkdiv),
        .rst       (rst),
        .wire_word (wire_word_s),
        .load      (boundary_s),
        .slot      (slot_nxt_s),
        .slip      (slip_nxt_s),
        .ser_data  (ser_data)
    );

    assign training_active = training_active_r;
    assign underflow_cnt   = underflow_cnt_r;

endmodule

// File: tb/tb_gsense_tx_lane.sv
// Directed bench: dut_a is 12/6/LSB, dut_b is 12/12/MSB.
module tb_gsense_tx_lane;
    import gsense_pkg::*;

    logic        clkdiv;
    logic        rst;
    logic [11:0] training_pattern;
    logic        train_a;
    logic        train_b;
    logic [3:0]  slip_offset;

    logic [5:0]  ser_a;
    logic        ta_a;
    logic [15:0] cnt_a;
    logic [11:0] ser_b;
    logic        ta_b;
    logic [15:0] cnt_b;

    int checks;
    int failures;

    gsense_tx_if #(.DATA_BITS(12)) if_a ();
    gsense_tx_if #(.DATA_BITS(12)) if_b ();

    gsense_tx_lane #(.DATA_BITS(12), .SER_WIDTH(6), .FIRST_BIT("LSB")) dut_a (
        .clkdiv           (clkdiv),
        .rst              (rst),
        .training_pattern (training_pattern),
        .train            (train_a),
        .slip_offset      (slip_offset),
        .s_if             (if_a.slave),
        .ser_data         (ser_a),
        .training_active  (ta_a),
        .underflow_cnt    (cnt_a)
    );

    gsense_tx_lane #(.DATA_BITS(12), .SER_WIDTH(12), .FIRST_BIT("MSB")) dut_b (
        .clkdiv           (clkdiv),
        .rst              (rst),
        .training_pattern (training_pattern),
        .train            (train_b),
        .slip_offset      (slip_offset),
        .s_if             (if_b.slave),
        .ser_data         (ser_b),
        .training_active  (ta_b),
        .underflow_cnt    (cnt_b)
    );

    initial clkdiv = 1'b0;
    always #5 clkdiv = ~clkdiv;

    task automatic tick();
        @(posedge clkdiv);
        @(negedge clkdiv);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        training_pattern = 12'h0FC;
        train_a = 1'b1;
        train_b = 1'b1;
        slip_offset = 4'd0;
        if_a.s_valid = 1'b0;
        if_a.s_data  = 12'h000;
        if_b.s_valid = 1'b0;
        if_b.s_data  = 12'h000;
        @(negedge clkdiv);
        @(negedge clkdiv);
        checks++; if (ser_a !== 6'h00) begin failures++; $display("FAIL reset_ser_a got=%h exp=00", ser_a); end
        checks++; if (if_a.s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_a got=%b exp=0", if_a.s_ready); end
        checks++; if (ta_a !== 1'b1) begin failures++; $display("FAIL reset_ta_a got=%b exp=1", ta_a); end
        checks++; if (cnt_a !== 16'h0000) begin failures++; $display("FAIL reset_cnt_a got=%h exp=0000", cnt_a); end
        checks++; if (ser_b !== 12'h000) begin failures++; $display("FAIL reset_ser_b got=%h exp=000", ser_b); end
        checks++; if (if_b.s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_b got=%b exp=0", if_b.s_ready); end
        rst = 1'b0;
        tick();
        checks++; if (ser_a !== 6'h00) begin failures++; $display("FAIL pre_word_ser_a got=%h exp=00", ser_a); end
        checks++; if (if_a.s_ready !== 1'b0) begin failures++; $display("FAIL train_ready_a got=%b exp=0", if_a.s_ready); end
    endtask

    task automatic test_training();
        for (int w = 0; w < 4; w++) begin
            tick();
            checks++; if (ser_a !== 6'h3C) begin failures++; $display("FAIL train_chunk0 w=%0d got=%h exp=3c", w, ser_a); end
            tick();
            checks++; if (ser_a !== 6'h03) begin failures++; $display("FAIL train_chunk1 w=%0d got=%h exp=03", w, ser_a); end
            checks++; if (if_a.s_ready !== 1'b0) begin failures++; $display("FAIL train_ready w=%0d got=%b exp=0", w, if_a.s_ready); end
            checks++; if (ta_a !== 1'b1) begin failures++; $display("FAIL train_ta w=%0d got=%b exp=1", w, ta_a); end
            checks++; if (cnt_a !== 16'h0000) begin failures++; $display("FAIL train_cnt w=%0d got=%h exp=0000", w, cnt_a); end
        end
    endtask

    task automatic test_stream();
        train_a = 1'b0;
        if_a.s_valid = 1'b1;
        if_a.s_data  = 12'hABC;
        #1;
        checks++; if (if_a.s_ready !== 1'b1) begin failures++; $display("FAIL stream_ready0 got=%b exp=1", if_a.s_ready); end
        tick();
        checks++; if (ser_a !== 6'h3C) begin failures++; $display("FAIL stream_abc0 got=%h exp=3c", ser_a); end
        checks++; if (ta_a !== 1'b0) begin failures++; $display("FAIL stream_ta got=%b exp=0", ta_a); end
        checks++; if (if_a.s_ready !== 1'b0) begin failures++; $display("FAIL stream_ready_mid got=%b exp=0", if_a.s_ready); end
        if_a.s_data = 12'h123;
        tick();
        checks++; if (ser_a !== 6'h2A) begin failures++; $display("FAIL stream_abc1 got=%h exp=2a", ser_a); end
        checks++; if (if_a.s_ready !== 1'b1) begin failures++; $display("FAIL stream_ready1 got=%b exp=1", if_a.s_ready); end
        tick();
        checks++; if (ser_a !== 6'h23) begin failures++; $display("FAIL stream_123_0 got=%h exp=23", ser_a); end
        tick();
        checks++; if (ser_a !== 6'h04) begin failures++; $display("FAIL stream_123_1 got=%h exp=04", ser_a); end
        checks++; if (ta_a !== 1'b0) begin failures++; $display("FAIL stream_ta2 got=%b exp=0", ta_a); end
        if_a.s_valid = 1'b0;
    endtask

    task automatic test_underflow();
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (ser_a !== 6'h3C) begin failures++; $display("FAIL idle_chunk0 i=%0d got=%h exp=3c", i, ser_a); end
            checks++; if (cnt_a !== 16'(i)) begin failures++; $display("FAIL idle_cnt i=%0d got=%0d exp=%0d", i, cnt_a, i); end
            checks++; if (ta_a !== 1'b1) begin failures++; $display("FAIL idle_ta i=%0d got=%b exp=1", i, ta_a); end
            tick();
            checks++; if (ser_a !== 6'h03) begin failures++; $display("FAIL idle_chunk1 i=%0d got=%h exp=03", i, ser_a); end
        end
    endtask

    task automatic test_slip();
        train_a = 1'b1;
        slip_offset = 4'd3;
        for (int w = 0; w < 3; w++) begin
            tick();
            checks++; if (ser_a !== 6'h20) begin failures++; $display("FAIL slip3_chunk0 w=%0d got=%h exp=20", w, ser_a); end
            tick();
            checks++; if (ser_a !== 6'h1F) begin failures++; $display("FAIL slip3_chunk1 w=%0d got=%h exp=1f", w, ser_a); end
        end
        checks++; if (cnt_a !== 16'd5) begin failures++; $display("FAIL slip_cnt_hold got=%0d exp=5", cnt_a); end
        // 15 clamps to 11
        slip_offset = 4'd15;
        for (int w = 0; w < 2; w++) begin
            tick();
            checks++; if (ser_a !== 6'h3E) begin failures++; $display("FAIL slip_clamp_chunk0 w=%0d got=%h exp=3e", w, ser_a); end
            tick();
            checks++; if (ser_a !== 6'h01) begin failures++; $display("FAIL slip_clamp_chunk1 w=%0d got=%h exp=01", w, ser_a); end
        end
        slip_offset = 4'd0;
    endtask

    task automatic test_reset_midword();
        train_a = 1'b0;
        if_a.s_valid = 1'b1;
        if_a.s_data  = 12'hABC;
        #1;
        checks++; if (if_a.s_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_pre got=%b exp=1", if_a.s_ready); end
        rst = 1'b1;
        #1;
        checks++; if (ser_a !== 6'h00) begin failures++; $display("FAIL mid_rst_ser got=%h exp=00", ser_a); end
        checks++; if (if_a.s_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", if_a.s_ready); end
        checks++; if (cnt_a !== 16'h0000) begin failures++; $display("FAIL mid_rst_cnt got=%h exp=0000", cnt_a); end
        @(negedge clkdiv);
        rst = 1'b0;
        tick();
        checks++; if (ser_a !== 6'h00) begin failures++; $display("FAIL post_rst_ser got=%h exp=00", ser_a); end
        checks++; if (if_a.s_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", if_a.s_ready); end
        tick();
        checks++; if (ser_a !== 6'h3C) begin failures++; $display("FAIL post_rst_w0 got=%h exp=3c", ser_a); end
        checks++; if (ta_a !== 1'b0) begin failures++; $display("FAIL post_rst_ta got=%b exp=0", ta_a); end
        tick();
        checks++; if (ser_a !== 6'h2A) begin failures++; $display("FAIL post_rst_w1 got=%h exp=2a", ser_a); end
        if_a.s_valid = 1'b0;
        train_a = 1'b1;
    endtask

    task automatic test_back_to_back();
        train_b = 1'b0;
        if_b.s_valid = 1'b1;
        if_b.s_data  = 12'hABC;
        #1;
        checks++; if (if_b.s_ready !== 1'b1) begin failures++; $display("FAIL b_ready0 got=%b exp=1", if_b.s_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (ser_b !== 12'h3D5) begin failures++; $display("FAIL b_abc i=%0d got=%h exp=3d5", i, ser_b); end
            checks++; if (if_b.s_ready !== 1'b1) begin failures++; $display("FAIL b_ready i=%0d got=%b exp=1", i, if_b.s_ready); end
            checks++; if (ta_b !== 1'b0) begin failures++; $display("FAIL b_ta i=%0d got=%b exp=0", i, ta_b); end
        end
        if_b.s_data = 12'h123;
        tick();
        checks++; if (ser_b !== 12'hC48) begin failures++; $display("FAIL b_123 got=%h exp=c48", ser_b); end
        if_b.s_valid = 1'b0;
        tick();
        checks++; if (ser_b !== 12'h3F0) begin failures++; $display("FAIL b_idle got=%h exp=3f0", ser_b); end
        checks++; if (ta_b !== 1'b1) begin failures++; $display("FAIL b_idle_ta got=%b exp=1", ta_b); end
        checks++; if (cnt_b !== 16'd1) begin failures++; $display("FAIL b_idle_cnt got=%0d exp=1", cnt_b); end
    endtask

    task automatic test_saturation();
        repeat (65540) begin
            @(posedge clkdiv);
        end
        @(negedge clkdiv);
        checks++; if (cnt_b !== 16'hFFFF) begin failures++; $display("FAIL b_cnt_sat got=%h exp=ffff", cnt_b); end
        tick();
        checks++; if (cnt_b !== 16'hFFFF) begin failures++; $display("FAIL b_cnt_hold got=%h exp=ffff", cnt_b); end
        checks++; if (ser_b !== 12'h3F0) begin failures++; $display("FAIL b_sat_ser got=%h exp=3f0", ser_b); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_training();
        test_stream();
        test_underflow();
        test_slip();
        test_reset_midword();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
